// File: rtl/irda_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_pkg : shared IrDA receive-side types and SIP timing constants   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package irda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH     = 2'd1,
    ST_LOW      = 2'd2,
    ST_WAIT_LOW = 2'd3
  } sip_state_e;

  // Nominal SIP shape, shared with the SIP generator on the transmit side.
  localparam int SIP_NOM_HIGH = 64;
  localparam int SIP_NOM_LOW  = 284;
  localparam int SIP_HIGH_TOL = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irda_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_rx_sync : rx line synchronizer with registered rise/fall flags  |
// | Optional 3-sample majority filter: IRDA_SIP_DET_GLITCH_FILTER_EN     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irda_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       w_rx_s;
  logic       rx_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

`ifdef IRDA_SIP_DET_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       w_maj;

  // Any single-sample excursion is outvoted by its two neighbours.
  assign w_maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= w_maj;
    end
  end

  assign w_rx_s = filt_q;
`else
  assign w_rx_s = sync_q[1];
`endif

  // Edge flags are registered, so rx_o is the delayed level aligned with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rx_q   <= w_rx_s;
      rise_q <= w_rx_s & ~rx_q;
      fall_q <= ~w_rx_s & rx_q;
    end
  end

  assign rx_o   = rx_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/irda_sip_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irda_sip_det : IrDA MIR/FIR Serial Interaction Pulse detector        |
// | Glitch filter option: IRDA_SIP_DET_GLITCH_FILTER_EN                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irda_sip_det
  import irda_pkg::*;
#(
  parameter int HIGH_MIN = SIP_NOM_HIGH - SIP_HIGH_TOL,
  parameter int HIGH_MAX = SIP_NOM_HIGH + SIP_HIGH_TOL,
  parameter int LOW_MIN  = 256,
  parameter int CNT_W    = 9
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       fast_enable,
  input  logic       rx_i,
  input  logic       sip_cnt_clr_i,
  output logic       sip_det_o,
  output logic       sip_err_o,
  output logic [7:0] sip_cnt_o
);

  localparam logic [CNT_W-1:0] c_high_min = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] c_high_max = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] c_low_min  = CNT_W'(LOW_MIN);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  logic w_rx_lvl;
  logic w_rx_rise;
  logic w_rx_fall;

  irda_rx_sync u_rx_sync (
    .clk    (clk),
    .rst    (wb_rst_i),
    .rx_i   (rx_i),
    .rx_o   (w_rx_lvl),
    .rise_o (w_rx_rise),
    .fall_o (w_rx_fall)
  );

  sip_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             det_q;
  logic             err_q;
  logic [7:0]       sip_cnt_q;
  logic [7:0]       sip_cnt_d;
  logic             w_accept;

  assign cnt_inc_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + c_one;
  assign w_accept  = fast_enable && (state_q == ST_LOW) && (cnt_q >= c_low_min);

  always_ff @(posedge clk) begin
    if (wb_rst_i || !fast_enable) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      det_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_rx_rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= c_one;
          end
        end
        ST_HIGH: begin
          if (w_rx_fall) begin
            if (cnt_q >= c_high_min) begin
              state_q <= ST_LOW;
              cnt_q   <= c_one;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (w_rx_lvl) begin
            if (cnt_q >= c_high_max) begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_LOW;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOW: begin
          // A rise landing on the accept cycle already starts the next candidate.
          if (w_accept) begin
            det_q <= 1'b1;
            if (w_rx_rise) begin
              state_q <= ST_HIGH;
              cnt_q   <= c_one;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (w_rx_rise) begin
            err_q   <= 1'b1;
            state_q <= ST_HIGH;
            cnt_q   <= c_one;
          end else if (!w_rx_lvl) begin
            cnt_q <= cnt_inc_d;
          end
        end
        ST_WAIT_LOW: begin
          if (!w_rx_lvl) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Clear coinciding with an accept keeps that accept.
  always_comb begin
    sip_cnt_d = sip_cnt_q;
    if (w_accept) begin
      sip_cnt_d = sip_cnt_clr_i ? 8'd1 : sat_inc8(sip_cnt_q);
    end else if (sip_cnt_clr_i) begin
      sip_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      sip_cnt_q <= 8'd0;
    end else begin
      sip_cnt_q <= sip_cnt_d;
    end
  end

  assign sip_det_o = det_q;
  assign sip_err_o = err_q;
  assign sip_cnt_o = sip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_irda_sip_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irda_sip_det : scoreboard bench for irda_sip_det                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_irda_sip_det;
  import irda_pkg::*;

  localparam int HMIN = 56;
  localparam int HMAX = 72;
  localparam int LMIN = 256;
`ifdef IRDA_SIP_DET_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       fast_enable = 1'b1;
  logic       rx_i = 1'b0;
  logic       sip_cnt_clr_i = 1'b0;
  logic       sip_det_o;
  logic       sip_err_o;
  logic [7:0] sip_cnt_o;

  irda_sip_det dut (
    .clk           (clk),
    .wb_rst_i      (wb_rst_i),
    .fast_enable   (fast_enable),
    .rx_i          (rx_i),
    .sip_cnt_clr_i (sip_cnt_clr_i),
    .sip_det_o     (sip_det_o),
    .sip_err_o     (sip_err_o),
    .sip_cnt_o     (sip_cnt_o)
  );

  always #5 clk = ~clk;

  // Edge index: a value driven at a negedge is sampled by edge cyc+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_det;
    int at;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_det, input int at, input int cnt);
    exp_t e;
    e.is_det = is_det;
    e.at     = at;
    e.cnt    = cnt;
    sb.push_back(e);
  endtask

  function automatic int sat_add(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Reference rules for one pulse: high w samples starting at edge t_h, then l low samples.
  task automatic expect_pulse(input int t_h, input int w, input int l);
    int t_l;
    t_l = t_h + w;
    if (w > HMAX) begin
      push(1'b0, t_h + HMAX + LAT, 0);
    end else if (w < HMIN) begin
      push(1'b0, t_l + LAT, 0);
    end else if (l >= LMIN) begin
      model_cnt = sat_add(model_cnt);
      push(1'b1, t_l + LMIN + LAT, model_cnt);
    end else begin
      push(1'b0, t_l + l + LAT, 0);
    end
  endtask

  task automatic drive_raw(input int w, input int l, output int t_h);
    @(negedge clk);
    t_h  = cyc + 1;
    rx_i = 1'b1;
    repeat (w - 1) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic pulse(input int w, input int l);
    int t_h;
    @(negedge clk);
    t_h  = cyc + 1;
    rx_i = 1'b1;
    expect_pulse(t_h, w, l);
    repeat (w - 1) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sip_det_o || sip_err_o) begin
      if (sip_det_o && sip_err_o) check("det_err_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check(sip_det_o ? "unexpected_det" : "unexpected_err", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind_is_det", int'(sip_det_o), int'(mon_e.is_det));
        check("strobe_edge", cyc, mon_e.at);
        if (mon_e.is_det) check("cnt_at_det", int'(sip_cnt_o), mon_e.cnt);
      end
    end
  end

  initial begin
    int w;
    int l;
    int t_h;
    int acc;
    int budget;

    repeat (4) @(negedge clk);
    wb_rst_i = 1'b0;
    check("reset_det", int'(sip_det_o), 0);
    check("reset_err", int'(sip_err_o), 0);
    check("reset_cnt", int'(sip_cnt_o), 0);
    repeat (5) @(negedge clk);

    pulse(SIP_NOM_HIGH, 300);
    check("cnt_after_nominal", int'(sip_cnt_o), 1);
    pulse(HMIN - 1, 300);
    pulse(HMIN, 300);
    pulse(HMAX, 300);
    pulse(HMAX + 1, 300);
    pulse(64, 200);
    pulse(64, 300);
    check("cnt_after_directed", int'(sip_cnt_o), 4);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 5))
        0:       w = HMIN - 1;
        1:       w = HMIN;
        2:       w = HMAX;
        3:       w = HMAX + 1;
        default: w = int'($urandom_range(4, 110));
      endcase
      case ($urandom_range(0, 4))
        0:       l = LMIN - 1;
        1:       l = LMIN;
        2:       l = int'($urandom_range(4, LMIN - 2));
        default: l = int'($urandom_range(LMIN, 320));
      endcase
      if (i == 13) l = 300;
      pulse(w, l);
    end
    check("cnt_after_random", int'(sip_cnt_o), model_cnt);

    // Disabled: a nominal SIP produces nothing and the count holds.
    @(negedge clk);
    fast_enable = 1'b0;
    drive_raw(64, 300, t_h);
    fast_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("cnt_hold_disabled", int'(sip_cnt_o), model_cnt);

    // Single-cycle low glitch inside a 64-cycle high pulse.
    @(negedge clk);
    t_h  = cyc + 1;
    rx_i = 1'b1;
`ifdef IRDA_SIP_DET_GLITCH_FILTER_EN
    model_cnt = sat_add(model_cnt);
    push(1'b1, t_h + 64 + LMIN + LAT, model_cnt);
`else
    push(1'b0, t_h + 30 + LAT, 0);
    push(1'b0, t_h + 64 + LAT, 0);
`endif
    repeat (29) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (32) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (299) @(negedge clk);
    check("cnt_after_glitch", int'(sip_cnt_o), model_cnt);

    // Reset at low cycle 100 aborts the candidate and clears the count.
    @(negedge clk);
    rx_i = 1'b1;
    repeat (63) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (99) @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i  = 1'b0;
    model_cnt = 0;
    repeat (250) @(negedge clk);
    check("cnt_after_reset", int'(sip_cnt_o), 0);

    for (int i = 0; i < 256; i++) pulse(HMIN, LMIN);
    repeat (300) @(negedge clk);
    check("cnt_saturated", int'(sip_cnt_o), 255);

    // Clear in the same cycle as an accept.
    @(negedge clk);
    t_h  = cyc + 1;
    rx_i = 1'b1;
    acc  = t_h + 64 + LMIN + LAT;
    model_cnt = 1;
    push(1'b1, acc, 1);
    repeat (63) @(negedge clk);
    @(negedge clk);
    rx_i = 1'b0;
    while (cyc + 1 < acc) @(negedge clk);
    sip_cnt_clr_i = 1'b1;
    @(negedge clk);
    sip_cnt_clr_i = 1'b0;
    check("cnt_clr_with_accept", int'(sip_cnt_o), 1);
    repeat (60) @(negedge clk);

    sip_cnt_clr_i = 1'b1;
    @(negedge clk);
    sip_cnt_clr_i = 1'b0;
    model_cnt = 0;
    check("cnt_clr_alone", int'(sip_cnt_o), 0);

    budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("missing_strobe_at_edge", -1, mon_e.at);
    end
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
